// File: rtl/mul_pkg.sv
// mul_pkg: shared multiplier width default, counter width and FSM state encoding
package mul_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W = $clog2(WIDTH_DEF);
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN = 2'd1;
  localparam state_t DONE = 2'd2;
endpackage

// File: rtl/shift_add_mul8_ctrl.sv
// shift_add_mul8_ctrl: IDLE/RUN/DONE sequencer with iteration counter (clk,rst,start -> load,step,last,busy,done)
module shift_add_mul8_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic load,
  output logic step,
  output logic last,
  output logic busy,
  output logic done
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  always_comb begin
    load = (state == IDLE || state == DONE) && start;
    step = state == RUN;
    last = step && cnt == CW'(WIDTH - 1);
    busy = step;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= load ? RUN : last ? DONE : step ? RUN : IDLE;
      cnt <= load ? '0 : step ? cnt + CW'(1) : cnt;
    end
  end
endmodule

// File: rtl/shift_add_mul8.sv
// shift_add_mul8: sequential unsigned shift-add multiplier (clk,rst,start,a,b -> busy,done,product; ovf output when MUL_OVF_EN is defined)
module shift_add_mul8
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
`ifdef MUL_OVF_EN
  ,
  output logic               ovf
`endif
);
  logic load, step, last;
  logic [WIDTH-1:0] mcand, acc_hi, acc_lo;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] acc_nxt;
  shift_add_mul8_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk(clk),
    .rst(rst),
    .start(start),
    .load(load),
    .step(step),
    .last(last),
    .busy(busy),
    .done(done)
  );
  always_comb begin
    sum = {1'b0, acc_hi} + {1'b0, {WIDTH{acc_lo[0]}} & mcand};
    acc_nxt = {sum, acc_lo[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      product <= '0;
`ifdef MUL_OVF_EN
      ovf <= 1'b0;
`endif
    end else begin
      if (load) begin
        mcand <= a;
        acc_hi <= '0;
        acc_lo <= b;
      end else if (step) begin
        {acc_hi, acc_lo} <= acc_nxt;
      end
      if (last) begin
        product <= acc_nxt;
`ifdef MUL_OVF_EN
        ovf <= |acc_nxt[2*WIDTH-1:WIDTH];
`endif
      end
    end
  end
endmodule

// File: tb/tb_shift_add_mul8.sv
// tb_shift_add_mul8: directed and random checks of shift_add_mul8 against an arithmetic reference model
module tb_shift_add_mul8;
  logic clk = 0, rst, start;
  logic [7:0] a, b;
  logic busy, done;
  logic [15:0] product;
`ifdef MUL_OVF_EN
  logic ovf;
`endif
  int checks = 0, errors = 0, dcnt = 0;
  shift_add_mul8 dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .product(product)
`ifdef MUL_OVF_EN
    ,
    .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  int m_rem = 0;
  logic m_done = 0;
  logic [15:0] m_prod = 0, pa = 0, pb = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_rem <= 0;
      m_done <= 0;
      m_prod <= 0;
    end else if (m_rem != 0) begin
      m_rem <= m_rem - 1;
      m_done <= m_rem == 1;
      if (m_rem == 1) m_prod <= pa * pb;
    end else begin
      m_done <= 0;
      if (start) begin
        pa <= {8'h00, a};
        pb <= {8'h00, b};
        m_rem <= 8;
      end
    end
  end
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (done) dcnt++;
    chk("busy", {15'd0, busy}, {15'd0, m_rem != 0});
    chk("done", {15'd0, done}, {15'd0, m_done});
    chk("product", product, m_prod);
`ifdef MUL_OVF_EN
    chk("ovf", {15'd0, ovf}, {15'd0, m_prod[15:8] != 8'h00});
`endif
  endtask
  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 20);
  endtask
  task automatic mul(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp, input string nm);
    int n;
    a = x;
    b = y;
    start = 1;
    tick();
    start = 0;
    wait_done(n);
    chk({nm, "_lat"}, 16'(n), 16'd8);
    chk(nm, product, exp);
  endtask
  initial begin
    int n, d0;
    rst = 1;
    start = 0;
    a = 0;
    b = 0;
    repeat (2) tick();
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_product", product, 16'h0000);
    rst = 0;
    tick();
    mul(8'h0F, 8'h0F, 16'h00E1, "m0f0f");
`ifdef MUL_OVF_EN
    chk("ovf0", {15'd0, ovf}, 16'd0);
`endif
    mul(8'hFF, 8'hFF, 16'hFE01, "mffff");
    chk("model_pin", m_prod, 16'hFE01);
`ifdef MUL_OVF_EN
    chk("ovf1", {15'd0, ovf}, 16'd1);
`endif
    tick();
    a = 8'h00;
    b = 8'hAB;
    start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    chk("hold_prev", product, 16'hFE01);
    wait_done(n);
    chk("zero_lat", 16'(n), 16'd4);
    chk("zero", product, 16'h0000);
    tick();
    a = 8'h12;
    b = 8'h34;
    start = 1;
    tick();
    start = 0;
    d0 = dcnt;
    repeat (2) tick();
    a = 8'hFF;
    b = 8'hFF;
    start = 1;
    tick();
    start = 0;
    wait_done(n);
    chk("ign_lat", 16'(n), 16'd5);
    chk("ign", product, 16'h03A8);
    repeat (10) tick();
    chk("ign_one_done", 16'(dcnt - d0), 16'd1);
    chk("ign_idle", {15'd0, busy}, 16'd0);
    a = 8'h80;
    b = 8'h80;
    start = 1;
    tick();
    start = 0;
    repeat (3) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_busy", {15'd0, busy}, 16'd0);
    chk("mid_rst_done", {15'd0, done}, 16'd0);
    chk("mid_rst_product", product, 16'h0000);
    d0 = dcnt;
    repeat (12) tick();
    chk("mid_rst_nodone", 16'(dcnt - d0), 16'd0);
    mul(8'h03, 8'h05, 16'h000F, "m0305");
    tick();
    mul(8'h07, 8'h09, 16'h003F, "b2b0");
    a = 8'h10;
    b = 8'h10;
    start = 1;
    chk("b2b_gap", {15'd0, busy}, 16'd0);
    tick();
    start = 0;
    chk("b2b_busy", {15'd0, busy}, 16'd1);
    wait_done(n);
    chk("b2b_lat", 16'(n), 16'd8);
    chk("b2b1", product, 16'h0100);
    repeat (400) begin
      start = $urandom_range(1, 0) == 1;
      a = 8'($urandom);
      b = 8'($urandom);
      rst = $urandom_range(40, 0) == 0;
      tick();
    end
    rst = 0;
    start = 0;
    repeat (12) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
